// File: rtl/alu_rs.sv
// alu_rs: reservation station feeding a single integer ALU.
// Holds up to RS_SIZE decoded non-memory instructions, wakes their operands
// from the ROB commit broadcast, and dispatches the lowest-index ready entry
// each cycle. The result is registered and reported to the ROB with a commit
// class (WRITE/JUMP/BOTH/NOTHING).
// Optional build macro RS_SELF_FORWARD_EN: when defined, the station's own
// WRITE/BOTH result also wakes waiting operands, so dependents can dispatch
// without waiting for the ROB commit.
`timescale 1ns/1ps

module alu_rs #(
    parameter int RS_WIDTH  = 2,
    parameter int RS_SIZE   = 4,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_op,
    input  logic [ROB_WIDTH-1:0] iss_tag,
    input  logic [4:0]           iss_rd,
    input  logic [31:0]          iss_vj,
    input  logic [31:0]          iss_vk,
    input  logic                 iss_qj_busy,
    input  logic                 iss_qk_busy,
    input  logic [ROB_WIDTH-1:0] iss_qj,
    input  logic [ROB_WIDTH-1:0] iss_qk,
    input  logic [31:0]          iss_imm,
    input  logic [31:0]          iss_pc,
    input  logic                 upd_valid,
    input  logic [ROB_WIDTH-1:0] upd_tag,
    input  logic [31:0]          upd_data,
    output logic                 full,
    output logic                 to_rob,
    output logic [RS_WIDTH-1:0]  to_rob_index,
    output logic [ROB_WIDTH-1:0] to_rob_tag,
    output logic [2:0]           to_rob_op,
    output logic [4:0]           to_rob_rd,
    output logic [31:0]          to_rob_wdata,
    output logic [31:0]          to_rob_jump
);

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_XOR   = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
        OP_SLT   = 5'd8,  OP_SLTU = 5'd9,  OP_LUI  = 5'd10, OP_AUIPC = 5'd11,
        OP_JAL   = 5'd12, OP_JALR = 5'd13,
        OP_BEQ   = 5'd16, OP_BNE  = 5'd17, OP_BLT  = 5'd18, OP_BGE  = 5'd19,
        OP_BLTU  = 5'd20, OP_BGEU = 5'd21
    } alu_op_e;

    typedef enum logic [2:0] {
        RC_WRITE   = 3'd0,
        RC_JUMP    = 3'd1,
        RC_BOTH    = 3'd2,
        RC_NOTHING = 3'd4
    } rob_class_e;

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   qj_busy;
    logic [RS_SIZE-1:0]   qk_busy;
    alu_op_e              op_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] tag_q  [RS_SIZE];
    logic [4:0]           rd_q   [RS_SIZE];
    logic [31:0]          vj_q   [RS_SIZE];
    logic [31:0]          vk_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_q   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_q   [RS_SIZE];
    logic [31:0]          imm_q  [RS_SIZE];
    logic [31:0]          pc_q   [RS_SIZE];

    logic                 sel_valid;
    logic [RS_WIDTH-1:0]  sel_idx;
    logic [RS_WIDTH-1:0]  free_idx;
    logic                 issue_en;
    logic                 fwd_valid;

    rob_class_e           res_class;
    logic [31:0]          res_wdata;
    logic [31:0]          res_jump;

    assign full     = &busy;
    assign issue_en = iss_valid && !full && !clear;

`ifdef RS_SELF_FORWARD_EN
    assign fwd_valid = to_rob && (to_rob_op == RC_WRITE || to_rob_op == RC_BOTH);
`else
    assign fwd_valid = 1'b0;
`endif

    // A waiting tag is satisfied by the ROB broadcast or, if enabled, our own result.
    function automatic logic wake_hit(input logic [ROB_WIDTH-1:0] q);
        return (upd_valid && q == upd_tag) || (fwd_valid && q == to_rob_tag);
    endfunction

    function automatic logic [31:0] wake_data(input logic [ROB_WIDTH-1:0] q);
        return (upd_valid && q == upd_tag) ? upd_data : to_rob_wdata;
    endfunction

    // Lowest-index ready entry for dispatch and lowest-index free entry for issue.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy[i] && !qj_busy[i] && !qk_busy[i] && !sel_valid) begin
                sel_valid = 1'b1;
                sel_idx   = RS_WIDTH'(i);
            end
        end
        for (int unsigned i = RS_SIZE; i > 0; i--) begin
            if (!busy[i-1]) free_idx = RS_WIDTH'(i - 1);
        end
    end

    // ALU and branch evaluation for the selected entry.
    always_comb begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm_v;
        logic [31:0] pc_v;
        logic        take;
        a         = vj_q[sel_idx];
        b         = vk_q[sel_idx];
        imm_v     = imm_q[sel_idx];
        pc_v      = pc_q[sel_idx];
        take      = 1'b0;
        res_class = RC_WRITE;
        res_wdata = '0;
        res_jump  = '0;
        case (op_q[sel_idx])
            OP_ADD:   res_wdata = a + b;
            OP_SUB:   res_wdata = a - b;
            OP_AND:   res_wdata = a & b;
            OP_OR:    res_wdata = a | b;
            OP_XOR:   res_wdata = a ^ b;
            OP_SLL:   res_wdata = a << b[4:0];
            OP_SRL:   res_wdata = a >> b[4:0];
            OP_SRA:   res_wdata = $signed(a) >>> b[4:0];
            OP_SLT:   res_wdata = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU:  res_wdata = {31'b0, a < b};
            OP_LUI:   res_wdata = imm_v;
            OP_AUIPC: res_wdata = pc_v + imm_v;
            OP_JAL: begin
                res_class = RC_BOTH;
                res_wdata = pc_v + 32'd4;
                res_jump  = pc_v + imm_v;
            end
            OP_JALR: begin
                res_class = RC_BOTH;
                res_wdata = pc_v + 32'd4;
                res_jump  = (a + imm_v) & ~32'd1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op_q[sel_idx])
                    OP_BEQ:  take = (a == b);
                    OP_BNE:  take = (a != b);
                    OP_BLT:  take = ($signed(a) <  $signed(b));
                    OP_BGE:  take = ($signed(a) >= $signed(b));
                    OP_BLTU: take = (a <  b);
                    default: take = (a >= b);
                endcase
                if (take) begin
                    res_class = RC_JUMP;
                    res_jump  = pc_v + imm_v;
                end else begin
                    res_class = RC_NOTHING;
                end
            end
            default:  res_class = RC_NOTHING;
        endcase
    end

    // Entry storage: dispatch frees, issue fills, busy entries capture woken operands.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy    <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= OP_ADD;
                tag_q[i] <= '0;
                rd_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                busy <= '0;
            end else begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (sel_valid && sel_idx == RS_WIDTH'(i)) begin
                        busy[i] <= 1'b0;
                    end else if (issue_en && free_idx == RS_WIDTH'(i)) begin
                        busy[i]  <= 1'b1;
                        op_q[i]  <= alu_op_e'(iss_op);
                        tag_q[i] <= iss_tag;
                        rd_q[i]  <= iss_rd;
                        qj_q[i]  <= iss_qj;
                        qk_q[i]  <= iss_qk;
                        imm_q[i] <= iss_imm;
                        pc_q[i]  <= iss_pc;
                        if (iss_qj_busy && wake_hit(iss_qj)) begin
                            vj_q[i]    <= wake_data(iss_qj);
                            qj_busy[i] <= 1'b0;
                        end else begin
                            vj_q[i]    <= iss_vj;
                            qj_busy[i] <= iss_qj_busy;
                        end
                        if (iss_qk_busy && wake_hit(iss_qk)) begin
                            vk_q[i]    <= wake_data(iss_qk);
                            qk_busy[i] <= 1'b0;
                        end else begin
                            vk_q[i]    <= iss_vk;
                            qk_busy[i] <= iss_qk_busy;
                        end
                    end else if (busy[i]) begin
                        if (qj_busy[i] && wake_hit(qj_q[i])) begin
                            vj_q[i]    <= wake_data(qj_q[i]);
                            qj_busy[i] <= 1'b0;
                        end
                        if (qk_busy[i] && wake_hit(qk_q[i])) begin
                            vk_q[i]    <= wake_data(qk_q[i]);
                            qk_busy[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Registered result port; pulses for one cycle per dispatch.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            to_rob       <= 1'b0;
            to_rob_index <= '0;
            to_rob_tag   <= '0;
            to_rob_op    <= '0;
            to_rob_rd    <= '0;
            to_rob_wdata <= '0;
            to_rob_jump  <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                to_rob <= 1'b0;
            end else if (sel_valid) begin
                to_rob       <= 1'b1;
                to_rob_index <= sel_idx;
                to_rob_tag   <= tag_q[sel_idx];
                to_rob_op    <= res_class;
                to_rob_rd    <= rd_q[sel_idx];
                to_rob_wdata <= res_wdata;
                to_rob_jump  <= res_jump;
            end else begin
                to_rob <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed steps plus a short random op
// stream; expected results are queued at issue/wakeup and popped per pulse.
`timescale 1ns/1ps

module tb_alu_rs;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        iss_valid;
    logic [4:0]  iss_op;
    logic [3:0]  iss_tag;
    logic [4:0]  iss_rd;
    logic [31:0] iss_vj, iss_vk;
    logic        iss_qj_busy, iss_qk_busy;
    logic [3:0]  iss_qj, iss_qk;
    logic [31:0] iss_imm, iss_pc;
    logic        upd_valid;
    logic [3:0]  upd_tag;
    logic [31:0] upd_data;
    logic        full;
    logic        to_rob;
    logic [1:0]  to_rob_index;
    logic [3:0]  to_rob_tag;
    logic [2:0]  to_rob_op;
    logic [4:0]  to_rob_rd;
    logic [31:0] to_rob_wdata, to_rob_jump;

    alu_rs #(.RS_WIDTH(2), .RS_SIZE(4), .ROB_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .iss_valid(iss_valid), .iss_op(iss_op), .iss_tag(iss_tag), .iss_rd(iss_rd),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy),
        .iss_qj(iss_qj), .iss_qk(iss_qk), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .upd_valid(upd_valid), .upd_tag(upd_tag), .upd_data(upd_data),
        .full(full), .to_rob(to_rob), .to_rob_index(to_rob_index), .to_rob_tag(to_rob_tag),
        .to_rob_op(to_rob_op), .to_rob_rd(to_rob_rd), .to_rob_wdata(to_rob_wdata),
        .to_rob_jump(to_rob_jump)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0]  tag;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic [31:0] wdata;
        logic [31:0] jump;
        logic        cw;
        logic        cj;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input logic [3:0] tag, input logic [4:0] rd);
        exp_t e;
        logic tk;
        e.tag = tag; e.rd = rd; e.op = 3'd0; e.wdata = '0; e.jump = '0;
        e.cw = 1'b1; e.cj = 1'b0; tk = 1'b0;
        case (op)
            5'd0:  e.wdata = a + b;
            5'd1:  e.wdata = a - b;
            5'd2:  e.wdata = a & b;
            5'd3:  e.wdata = a | b;
            5'd4:  e.wdata = a ^ b;
            5'd5:  e.wdata = a << b[4:0];
            5'd6:  e.wdata = a >> b[4:0];
            5'd7:  e.wdata = $signed(a) >>> b[4:0];
            5'd8:  e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  e.wdata = (a < b) ? 32'd1 : 32'd0;
            5'd10: e.wdata = imm;
            5'd11: e.wdata = pc + imm;
            5'd12: begin e.op = 3'd2; e.wdata = pc + 32'd4; e.jump = pc + imm; e.cj = 1'b1; end
            5'd13: begin e.op = 3'd2; e.wdata = pc + 32'd4; e.jump = (a + imm) & 32'hFFFF_FFFE; e.cj = 1'b1; end
            default: begin
                case (op)
                    5'd16: tk = (a == b);
                    5'd17: tk = (a != b);
                    5'd18: tk = ($signed(a) < $signed(b));
                    5'd19: tk = ($signed(a) >= $signed(b));
                    5'd20: tk = (a < b);
                    5'd21: tk = (a >= b);
                    default: tk = 1'b0;
                endcase
                if (tk) begin
                    e.op = 3'd1; e.jump = pc + imm; e.cj = 1'b1;
                end else begin
                    e.op = 3'd4; e.cw = 1'b0;
                end
            end
        endcase
        return e;
    endfunction

    // One clock; any result pulse produced at an enabled edge is checked against the queue.
    task automatic tick();
        logic was_rdy;
        exp_t e;
        was_rdy = rdy_in;
        @(posedge clk_in);
        #1;
        if (was_rdy && to_rob) begin
            chk("expected_result_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("res_tag", 32'(to_rob_tag), 32'(e.tag));
                chk("res_rd",  32'(to_rob_rd),  32'(e.rd));
                chk("res_op",  32'(to_rob_op),  32'(e.op));
                if (e.cw) chk("res_wdata", to_rob_wdata, e.wdata);
                if (e.cj) chk("res_jump",  to_rob_jump,  e.jump);
            end
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] tag, input logic [4:0] rd,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic qjb, input logic [3:0] qj, input logic qkb, input logic [3:0] qk,
                         input logic [31:0] imm, input logic [31:0] pc);
        iss_valid = 1'b1; iss_op = op; iss_tag = tag; iss_rd = rd; iss_vj = vj; iss_vk = vk;
        iss_qj_busy = qjb; iss_qj = qj; iss_qk_busy = qkb; iss_qk = qk; iss_imm = imm; iss_pc = pc;
        tick();
        iss_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ops [20];
        logic [4:0]  op;
        logic [31:0] a, b, pc, imm;
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                5'd11, 5'd12, 5'd13, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};

        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; iss_valid = 1'b0; iss_op = '0;
        iss_tag = '0; iss_rd = '0; iss_vj = '0; iss_vk = '0; iss_qj_busy = 1'b0;
        iss_qk_busy = 1'b0; iss_qj = '0; iss_qk = '0; iss_imm = '0; iss_pc = '0;
        upd_valid = 1'b0; upd_tag = '0; upd_data = '0;

        // reset state
        tick(); tick();
        chk("rst_full",   32'(full),   32'd0);
        chk("rst_to_rob", 32'(to_rob), 32'd0);
        chk("rst_tag",    32'(to_rob_tag), 32'd0);
        chk("rst_op",     32'(to_rob_op),  32'd0);
        chk("rst_wdata",  to_rob_wdata, 32'd0);
        chk("rst_jump",   to_rob_jump,  32'd0);
        rst_in = 1'b0;
        tick();

        // ADD, both ready: pulse two cycles after issue, exactly one cycle long
        sb.push_back(model(5'd0, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 5'd1));
        issue(5'd0, 4'd3, 5'd1, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("add_not_yet", 32'(to_rob), 32'd0);
        tick();
        chk("add_pulse", 32'(to_rob), 32'd1);
        chk("add_wdata", to_rob_wdata, 32'd12);
        chk("add_index", 32'(to_rob_index), 32'd0);
        tick();
        chk("add_pulse_end", 32'(to_rob), 32'd0);

        // SUB waiting on tag 6
        issue(5'd1, 4'd5, 5'd2, 32'd0, 32'd4, 1'b1, 4'd6, 1'b0, 4'd0, 32'd0, 32'd0);
        tick(); tick();
        chk("sub_waiting", 32'(to_rob), 32'd0);
        upd_valid = 1'b1; upd_tag = 4'd6; upd_data = 32'd10;
        sb.push_back(model(5'd1, 32'd10, 32'd4, 32'd0, 32'd0, 4'd5, 5'd2));
        tick();
        upd_valid = 1'b0;
        chk("sub_wake_edge", 32'(to_rob), 32'd0);
        tick();
        chk("sub_pulse", 32'(to_rob), 32'd1);
        chk("sub_wdata", to_rob_wdata, 32'd6);
        tick();

        // issue captures a same-cycle broadcast
        upd_valid = 1'b1; upd_tag = 4'd7; upd_data = 32'd100;
        sb.push_back(model(5'd1, 32'd100, 32'd1, 32'd0, 32'd0, 4'd9, 5'd4));
        issue(5'd1, 4'd9, 5'd4, 32'd0, 32'd1, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 32'd0);
        upd_valid = 1'b0;
        tick();
        chk("same_cycle_wake_pulse", 32'(to_rob), 32'd1);
        tick();

        // branch and JALR corner cases
        sb.push_back(model(5'd18, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd2, 5'd0));
        issue(5'd18, 4'd2, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'h20, 32'h100);
        tick();
        chk("blt_op",   32'(to_rob_op), 32'd1);
        chk("blt_jump", to_rob_jump, 32'h120);
        sb.push_back(model(5'd13, 32'h203, 32'd0, 32'd0, 32'h40, 4'd4, 5'd5));
        issue(5'd13, 4'd4, 5'd5, 32'h203, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h40);
        tick();
        chk("jalr_op",    32'(to_rob_op), 32'd2);
        chk("jalr_wdata", to_rob_wdata, 32'h44);
        chk("jalr_jump",  to_rob_jump,  32'h202);
        tick();

        // random back-to-back stream of ready ops (results come out in issue order)
        for (int n = 0; n < 24; n++) begin
            op  = ops[$urandom_range(19)];
            a   = $urandom;
            b   = ($urandom_range(3) == 0) ? a : $urandom;
            imm = $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            sb.push_back(model(op, a, b, imm, pc, 4'(n), 5'(n + 1)));
            issue(op, 4'(n), 5'(n + 1), a, b, 1'b0, 4'd0, 1'b0, 4'd0, imm, pc);
        end
        tick(); tick();

        // fill all entries, drop a fifth request, free one via broadcast
        for (int i = 0; i < 4; i++) begin
            issue(5'd0, 4'(i), 5'(i + 1), 32'd0, 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0, 32'd0, 32'd0);
            chk("fill_full", 32'(full), (i == 3) ? 32'd1 : 32'd0);
        end
        issue(5'd0, 4'd12, 5'd9, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        chk("full_after_drop", 32'(full), 32'd1);
        upd_valid = 1'b1; upd_tag = 4'd9; upd_data = 32'd100;
        sb.push_back(model(5'd0, 32'd100, 32'd1, 32'd0, 32'd0, 4'd1, 5'd2));
        tick();
        upd_valid = 1'b0;
        chk("full_until_dispatch", 32'(full), 32'd1);
        tick();
        chk("full_released", 32'(full), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i != 1) begin
                upd_valid = 1'b1; upd_tag = 4'(8 + i); upd_data = 32'(50 + i);
                sb.push_back(model(5'd0, 32'(50 + i), 32'(i), 32'd0, 32'd0, 4'(i), 5'(i + 1)));
                tick();
                upd_valid = 1'b0;
                tick();
            end
        end
        tick();
        chk("drained_full", 32'(full), 32'd0);

        // clear in the same cycle as an issue and a dispatch
        issue(5'd0, 4'd1, 5'd3, 32'd5, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        clear = 1'b1;
        issue(5'd0, 4'd2, 5'd3, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        clear = 1'b0;
        chk("clear_to_rob", 32'(to_rob), 32'd0);
        chk("clear_full",   32'(full),   32'd0);
        tick(); tick();
        chk("clear_quiet", 32'(to_rob), 32'd0);
        for (int i = 0; i < 4; i++) begin
            issue(5'd0, 4'(i), 5'd1, 32'd0, 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 32'd0, 32'd0);
            chk("clear_refill_full", 32'(full), (i == 3) ? 32'd1 : 32'd0);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_empties", 32'(full), 32'd0);

        // rdy_in low freezes dispatch, issue and outputs
        issue(5'd0, 4'd4, 5'd7, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        rdy_in = 1'b0;
        tick();
        chk("stall_no_dispatch", 32'(to_rob), 32'd0);
        tick();
        chk("stall_no_dispatch2", 32'(to_rob), 32'd0);
        rdy_in = 1'b1;
        sb.push_back(model(5'd0, 32'd1, 32'd1, 32'd0, 32'd0, 4'd4, 5'd7));
        tick();
        chk("stall_release_pulse", 32'(to_rob), 32'd1);
        rdy_in = 1'b0;
        tick();
        chk("stall_hold_to_rob", 32'(to_rob), 32'd1);
        chk("stall_hold_wdata", to_rob_wdata, 32'd2);
        rdy_in = 1'b1;
        tick();
        chk("stall_pulse_end", 32'(to_rob), 32'd0);
        rdy_in = 1'b0;
        issue(5'd0, 4'd5, 5'd7, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        rdy_in = 1'b1;
        chk("stall_issue_ignored", 32'(full), 32'd0);
        tick(); tick();
        chk("stall_issue_no_result", 32'(to_rob), 32'd0);

        // dependent on tag 3 behind a producer in the station
        sb.push_back(model(5'd0, 32'd1, 32'd2, 32'd0, 32'd0, 4'd3, 5'd5));
        issue(5'd0, 4'd3, 5'd5, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
`ifdef RS_SELF_FORWARD_EN
        sb.push_back(model(5'd0, 32'd3, 32'd10, 32'd0, 32'd0, 4'd6, 5'd6));
        issue(5'd0, 4'd6, 5'd6, 32'd0, 32'd10, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("fwd_dispatch", 32'(to_rob), 32'd1);
        chk("fwd_wdata", to_rob_wdata, 32'd13);
`else
        issue(5'd0, 4'd6, 5'd6, 32'd0, 32'd10, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 32'd0);
        tick(); tick();
        chk("dep_waits_for_commit", 32'(to_rob), 32'd0);
        upd_valid = 1'b1; upd_tag = 4'd3; upd_data = 32'd3;
        sb.push_back(model(5'd0, 32'd3, 32'd10, 32'd0, 32'd0, 4'd6, 5'd6));
        tick();
        upd_valid = 1'b0;
        tick();
        chk("dep_dispatch", 32'(to_rob), 32'd1);
        chk("dep_wdata", to_rob_wdata, 32'd13);
`endif
        tick();

        // asynchronous reset mid-run with entries busy and a pulse in flight
        issue(5'd0, 4'd7, 5'd1, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, 4'd0, 32'd0, 32'd0);
        issue(5'd0, 4'd8, 5'd1, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, 4'd0, 32'd0, 32'd0);
        sb.push_back(model(5'd0, 32'd5, 32'd5, 32'd0, 32'd0, 4'd9, 5'd2));
        issue(5'd0, 4'd9, 5'd2, 32'd5, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        chk("pre_reset_pulse", 32'(to_rob), 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("async_rst_to_rob", 32'(to_rob), 32'd0);
        chk("async_rst_full",   32'(full),   32'd0);
        chk("async_rst_wdata",  to_rob_wdata, 32'd0);
        tick();
        rst_in = 1'b0;
        upd_valid = 1'b1; upd_tag = 4'd14; upd_data = 32'd1;
        tick();
        upd_valid = 1'b0;
        tick(); tick();
        chk("rst_entries_gone", 32'(to_rob), 32'd0);
        for (int i = 0; i < 4; i++) begin
            issue(5'd0, 4'(i), 5'd1, 32'd0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0, 32'd0, 32'd0);
            chk("rst_refill_full", 32'(full), (i == 3) ? 32'd1 : 32'd0);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        tick();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
